// File: rtl/reg_scoreboard_if.sv
// Decode-stage issue bus, back-end completion buses and the scoreboard's
// stall/bypass response, bundled for the register scoreboard.
interface reg_scoreboard_if #(
  parameter int REG_LOGSIZE = 5,
  parameter int NUM_RD      = 2,
  parameter int NUM_WB      = 2
) ();
  localparam int SEL_W = $clog2(NUM_WB + 1);

  logic                          iss_valid;
  logic [NUM_RD*REG_LOGSIZE-1:0] iss_rs_addr;
  logic [NUM_RD-1:0]             iss_rs_used;
  logic [REG_LOGSIZE-1:0]        iss_rd_addr;
  logic                          iss_rd_we;
  logic                          iss_stall;
  logic                          iss_accept;
  logic [NUM_WB-1:0]             wb_valid;
  logic [NUM_WB*REG_LOGSIZE-1:0] wb_addr;
  logic [NUM_RD*SEL_W-1:0]       fwd_sel;

  modport master (
    output iss_valid, iss_rs_addr, iss_rs_used, iss_rd_addr, iss_rd_we,
    output wb_valid, wb_addr,
    input  iss_stall, iss_accept, fwd_sel
  );

  modport slave (
    input  iss_valid, iss_rs_addr, iss_rs_used, iss_rd_addr, iss_rd_we,
    input  wb_valid, wb_addr,
    output iss_stall, iss_accept, fwd_sel
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write scoreboard: RAW/WAW hazard stall for decode
// plus same-cycle bypass selects from the completion buses.
module reg_scoreboard #(
  parameter int REG_LOGSIZE = 5,
  parameter int NUM_RD      = 2,
  parameter int NUM_WB      = 2,
  parameter int CNT_W       = 2
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      flush,
  reg_scoreboard_if.slave           sb,
  output logic [2**REG_LOGSIZE-1:0] busy_vec,
  output logic                      err
);
  localparam int SEL_W = $clog2(NUM_WB + 1);
  localparam int NREG  = 2**REG_LOGSIZE;
  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  logic [CNT_W-1:0]        cnt_q [NREG];
  logic [CNT_W-1:0]        cnt_d [NREG];
  logic                    err_q, err_d;
  logic [NREG-1:0]         hit_any, hit_multi;
  logic [REG_LOGSIZE-1:0]  wb_a, rs_a;
  logic [SEL_W-1:0]        sel;
  logic [NUM_RD*SEL_W-1:0] fwd_sel;
  logic                    hazard, stall, accept, inc;

  // Completion hits per register; x0 is never a hit.
  always_comb begin
    hit_any   = '0;
    hit_multi = '0;
    wb_a      = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      wb_a = sb.wb_addr[k*REG_LOGSIZE +: REG_LOGSIZE];
      if (sb.wb_valid[k] && wb_a != '0) begin
        if (hit_any[wb_a]) hit_multi[wb_a] = 1'b1;
        hit_any[wb_a] = 1'b1;
      end
    end
  end

  always_comb begin
    hazard  = 1'b0;
    fwd_sel = '0;
    rs_a    = '0;
    sel     = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rs_a = sb.iss_rs_addr[i*REG_LOGSIZE +: REG_LOGSIZE];
      sel  = '0;
      // Descending scan so the lowest completion port wins.
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (sb.wb_valid[k] && sb.wb_addr[k*REG_LOGSIZE +: REG_LOGSIZE] == rs_a)
          sel = SEL_W'(k + 1);
      end
      if (sb.iss_rs_used[i] && rs_a != '0) begin
        if (cnt_q[rs_a] == CNT_W'(1) && sel != '0)
          fwd_sel[i*SEL_W +: SEL_W] = sel;
        else if (cnt_q[rs_a] != '0)
          hazard = 1'b1;
      end
    end
    if (sb.iss_rd_we && sb.iss_rd_addr != '0 &&
        cnt_q[sb.iss_rd_addr] == SAT && !hit_any[sb.iss_rd_addr])
      hazard = 1'b1;
    stall  = sb.iss_valid & hazard;
    accept = sb.iss_valid & ~stall;
  end

  assign sb.iss_stall  = stall;
  assign sb.iss_accept = accept;
  assign sb.fwd_sel    = fwd_sel;

  always_comb begin
    err_d = err_q;
    inc   = 1'b0;
    for (int r = 0; r < NREG; r++) cnt_d[r] = '0;
    if (!flush) begin
      for (int r = 1; r < NREG; r++) begin
        inc = accept & sb.iss_rd_we & (sb.iss_rd_addr == REG_LOGSIZE'(r));
        if (hit_any[r] && cnt_q[r] == '0) begin
          // Underflow: the stray completion is dropped, the counter never wraps.
          err_d    = 1'b1;
          cnt_d[r] = cnt_q[r] + CNT_W'(inc);
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_W'(inc) - CNT_W'(hit_any[r]);
        end
        if (hit_multi[r]) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) busy_vec[r] = (cnt_q[r] != '0);
  end

  assign err = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_scoreboard;
  logic        clk = 1'b0;
  logic        nrst;
  logic        flush;
  logic [31:0] busy_vec;
  logic        err;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.REG_LOGSIZE(5), .NUM_RD(2), .NUM_WB(2)) sb_if ();

  reg_scoreboard #(.REG_LOGSIZE(5), .NUM_RD(2), .NUM_WB(2), .CNT_W(2)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .flush    (flush),
    .sb       (sb_if),
    .busy_vec (busy_vec),
    .err      (err)
  );

  typedef struct {
    int          id;
    logic        stall;
    logic        acc;
    logic [1:0]  f0;
    logic [1:0]  f1;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step%0d %s: got %h expected %h", id, nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("stall",    e.id, 32'(sb_if.iss_stall),  32'(e.stall));
      cmp("accept",   e.id, 32'(sb_if.iss_accept), 32'(e.acc));
      if (e.acc) begin
        cmp("fwd_sel0", e.id, 32'(sb_if.fwd_sel[1:0]), 32'(e.f0));
        cmp("fwd_sel1", e.id, 32'(sb_if.fwd_sel[3:2]), 32'(e.f1));
      end
      cmp("busy_vec", e.id, busy_vec, e.busy);
      cmp("err",      e.id, 32'(err), 32'(e.err));
    end
  end

  // Apply one cycle of inputs, queue what the outputs must be before the edge.
  task automatic step(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [1:0] used, input logic [4:0] rd, input logic we,
                      input logic [1:0] wbv, input logic [4:0] a0, input logic [4:0] a1,
                      input logic fl, input logic xs, input logic [1:0] xf0,
                      input logic [1:0] xf1, input logic [31:0] xbusy, input logic xerr);
    exp_t e;
    sb_if.iss_valid   = v;
    sb_if.iss_rs_addr = {s1, s0};
    sb_if.iss_rs_used = used;
    sb_if.iss_rd_addr = rd;
    sb_if.iss_rd_we   = we;
    sb_if.wb_valid    = wbv;
    sb_if.wb_addr     = {a1, a0};
    flush             = fl;
    step_id++;
    e.id = step_id; e.stall = xs; e.acc = v & ~xs; e.f0 = xf0; e.f1 = xf1;
    e.busy = xbusy; e.err = xerr;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [31:0] xbusy, input logic xerr);
    step(0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, xbusy, xerr);
  endtask

  initial begin
    nrst = 1'b0;
    flush = 1'b0;
    sb_if.iss_valid = 0; sb_if.iss_rs_addr = '0; sb_if.iss_rs_used = '0;
    sb_if.iss_rd_addr = '0; sb_if.iss_rd_we = 0; sb_if.wb_valid = '0; sb_if.wb_addr = '0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    // Plain issue, then busy bit appears
    step(1, 3, 4, 2'b11, 5, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    idle(32'h20, 0);
    // Same-cycle bypass of r5 from completion port 1
    step(1, 5, 0, 2'b01, 0, 0, 2'b10, 0, 5, 0, 0, 2, 0, 32'h20, 0);
    idle(32'h0, 0);

    // Two writes to r7, then a reader waiting for both completions
    step(1, 0, 0, 2'b00, 7, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 2'b00, 7, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h80, 0);
    step(1, 7, 7, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h80, 0);
    step(1, 7, 0, 2'b01, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 32'h80, 0);
    step(1, 7, 0, 2'b01, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 32'h80, 0);
    step(1, 7, 0, 2'b01, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 32'h80, 0);
    step(1, 7, 0, 2'b01, 0, 0, 2'b01, 7, 0, 0, 1, 0, 0, 32'h80, 0);
    step(1, 7, 0, 2'b01, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 32'h80, 0);
    step(1, 7, 0, 2'b01, 0, 0, 2'b01, 7, 0, 0, 0, 1, 0, 32'h80, 0);
    idle(32'h0, 0);

    // Saturation on r9
    step(1, 0, 0, 2'b00, 9, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 2'b00, 9, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h200, 0);
    step(1, 0, 0, 2'b00, 9, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h200, 0);
    step(1, 0, 0, 2'b00, 9, 1, 2'b00, 0, 0, 0, 1, 0, 0, 32'h200, 0);
    step(1, 0, 0, 2'b00, 9, 1, 2'b00, 0, 0, 0, 1, 0, 0, 32'h200, 0);
    step(1, 0, 0, 2'b00, 9, 1, 2'b01, 9, 0, 0, 0, 0, 0, 32'h200, 0);
    // cnt[9] must still be 3: reader stalls even with a hit, then drains
    step(1, 9, 0, 2'b01, 0, 0, 2'b01, 9, 0, 0, 1, 0, 0, 32'h200, 0);
    step(0, 0, 0, 2'b00, 0, 0, 2'b10, 0, 9, 0, 0, 0, 0, 32'h200, 0);
    step(1, 9, 0, 2'b01, 0, 0, 2'b10, 0, 9, 0, 0, 2, 0, 32'h200, 0);
    idle(32'h0, 0);

    // x0 everywhere, including two completions to x0
    step(1, 0, 0, 2'b11, 0, 1, 2'b11, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    idle(32'h0, 0);

    // Flush with cnt[2]=2 and a concurrent issue to r2
    step(1, 0, 0, 2'b00, 2, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 2'b00, 2, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h4, 0);
    step(1, 0, 0, 2'b00, 2, 1, 2'b00, 0, 0, 1, 0, 0, 0, 32'h4, 0);
    idle(32'h0, 0);

    // Underflow on r6 sets sticky err; survives flush, cleared by reset
    step(0, 0, 0, 2'b00, 0, 0, 2'b01, 6, 0, 0, 0, 0, 0, 32'h0, 0);
    idle(32'h0, 1);
    step(0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 32'h0, 1);
    step(1, 0, 0, 2'b00, 12, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    nrst = 1'b0;
    idle(32'h1000, 1);
    nrst = 1'b1;
    idle(32'h0, 0);

    // Double completion on one register: lowest port bypasses, one decrement
    step(1, 0, 0, 2'b00, 10, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 2'b00, 10, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h400, 0);
    step(1, 0, 0, 2'b00, 11, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h400, 0);
    step(1, 11, 0, 2'b01, 0, 0, 2'b11, 11, 11, 0, 0, 1, 0, 32'hC00, 0);
    step(0, 0, 0, 2'b00, 0, 0, 2'b11, 10, 10, 0, 0, 0, 0, 32'h400, 1);
    step(0, 0, 0, 2'b00, 0, 0, 2'b01, 10, 0, 0, 0, 0, 0, 32'h400, 1);
    idle(32'h0, 1);

    begin
      int budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Parametrised register scoreboard and hazard unit for the RISC-V core pipeline. It replaces fixed EXE/MEM distance forwarding with per-register outstanding-write tracking, so variable-latency producers (loads with DRAM wait states, future mul/div) can share the issue point. It sits in the decode stage. It takes decoded register fields and write-completion buses from the back-end, and produces the decode stall plus per-read-port bypass selects.

Parameters:
REG_LOGSIZE, 5, register address width; the register file holds 2**REG_LOGSIZE registers.
NUM_RD, 2, number of source-operand read ports checked per issued instruction.
NUM_WB, 2, number of write-completion ports (one per result bus).
CNT_W, 2, width of the per-register outstanding-write counter; saturation value is 2**CNT_W-1.
SEL_W, $clog2(NUM_WB+1), width of each bypass select field (derived; not to be overridden).

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
flush  in  1  discard all outstanding writes (pipeline kill)
iss_valid  in  1  decode holds a valid instruction
iss_rs_addr  in  NUM_RD*REG_LOGSIZE  source register addresses; port i at bits [i*REG_LOGSIZE +: REG_LOGSIZE]
iss_rs_used  in  NUM_RD  port i source is actually read
iss_rd_addr  in  REG_LOGSIZE  destination register
iss_rd_we  in  1  instruction writes iss_rd_addr
iss_stall  out  1  hold decode and fetch (combinational)
iss_accept  out  1  iss_valid & ~iss_stall (combinational)
wb_valid  in  NUM_WB  completion port k presents a result this cycle
wb_addr  in  NUM_WB*REG_LOGSIZE  destination of completion port k
fwd_sel  out  NUM_RD*SEL_W  per read port: 0 = register file, k = bypass from completion port k-1
busy_vec  out  2**REG_LOGSIZE  bit r set when cnt[r] != 0 (registered view)
err  out  1  sticky protocol error flag

Behaviour:
- State: cnt[r] for r = 1..2**REG_LOGSIZE-1. Register x0 is never tracked: cnt[0] == 0, issues to x0 are ignored, and sources equal to x0 never stall or bypass.
- Reset (nrst low at posedge): all cnt = 0, err = 0, busy_vec = 0. Reset during outstanding writes discards them.
- Hit: wb_hit[k][r] = wb_valid[k] & (wb_addr k == r) & (r != 0).
- RAW check, source port i with iss_rs_used[i] and address s != 0:
  - cnt[s] == 0: no hazard; fwd_sel = 0.
  - cnt[s] == 1 and some port k has wb_hit: no hazard; fwd_sel = k+1 (same-cycle bypass of the last outstanding write).
  - Otherwise (cnt[s] >= 2, or cnt[s] == 1 with no hit): hazard.
- WAW saturation: if iss_rd_we and d = iss_rd_addr != 0 and cnt[d] == saturation and no wb_hit on d, raise a hazard.
- iss_stall = iss_valid & (any hazard). It is purely combinational from inputs and state; no cycle of latency.
- fwd_sel is computed regardless of iss_valid; it is defined only while iss_accept is high.
- Counter update at posedge when flush is low: cnt_next[r] = cnt[r] + (iss_accept & iss_rd_we & rd == r) - (number of ports k with wb_hit[k][r]). Issue and completion on the same register in the same cycle leave cnt unchanged.
- Two or more wb ports hitting the same nonzero register in one cycle is illegal. Response: err is set, cnt decrements by one only, and the lowest k wins for fwd_sel.
- Completion on a register with cnt == 0 is an underflow. Response: err is set and cnt stays 0.
- Flush high at posedge: all cnt = 0 next cycle. Issue and completion in that same cycle are ignored. iss_stall is still computed normally during the flush cycle. err is unaffected.
- err clears only on reset.
- busy_vec reflects the registered cnt and does not include same-cycle updates.
- The counter never wraps: saturation blocks the increment via stall, and underflow is clamped.

Test Plan:
1. Reset, then issue rs1 = 3, rs2 = 4, rd = 5 with we -> iss_stall = 0, fwd_sel = 0/0; next cycle cnt[5] = 1 and busy_vec[5] = 1.
2. cnt[5] = 1, issue rs1 = 5 with wb_valid[1] = 1, wb_addr1 = 5 in the same cycle -> iss_stall = 0, fwd_sel port0 = 2; next cycle cnt[5] = 0.
3. Issue two writes to r7 back-to-back (cnt = 2), then an instruction reading r7; deliver wb to r7 on port 0 at cycles +3 and +5 -> stall held until the cycle of the second wb, where fwd_sel = 1 and accept = 1.
4. CNT_W = 2: issue four writes to r9 with no completions -> the fourth issue stalls (cnt = 3); in the cycle a wb to r9 arrives, the fourth issue is accepted and cnt stays 3.
5. Source = x0 with iss_rd_addr = 0 and wb to addr 0 -> never stalls, fwd_sel = 0, no counter change, err = 0.
6. cnt[2] = 2 and flush together with a new issue to r2 -> next cycle all cnt = 0. Separately: wb to r6 with cnt[6] = 0 -> err = 1 and remains 1 until nrst low.
